uart_hex_tx: RTL and testbench
==============================

UART_HEX_TX -- requirements
Module: uart_hex_tx

Interface
REQ-001 Parameter CLK_CYCLES, default 87, SHALL be the clk cycles per UART bit (87 = 115,200 baud at 10 MHz).
REQ-002 Parameter N, default 4, SHALL be the number of hex digits sent per frame (value width = 4*N bits).
REQ-003 clk  input  1  single clock; all logic on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 value  input  4*N  number to transmit, sampled on an accepted start.
REQ-006 start  input  1  single-cycle request to send one frame.
REQ-007 busy  output  1  high while a frame is in progress.
REQ-008 done  output  1  one-cycle pulse when the last frame bit completes.
REQ-009 uart_tx  output  1  serial line, idle high.

Function
REQ-010 Frame SHALL be N ASCII hex characters (MSB nibble first, uppercase '0'-'9','A'-'F'), then 0x0D, then 0x0A.
REQ-011 Each character SHALL be 8N1: one start bit (0), 8 data bits LSB first, one stop bit (1), each held exactly CLK_CYCLES cycles.
REQ-012 Characters SHALL be sent back-to-back: the next start bit begins the cycle after the previous stop bit ends.
REQ-013 start SHALL be accepted only when busy is low; on an accepted start at cycle 0, value SHALL be latched in the same edge.
REQ-014 For a start accepted at cycle 0, uart_tx SHALL go low and busy high at cycle 1.
REQ-015 done SHALL pulse at cycle 1 + (N+2)*10*CLK_CYCLES; busy SHALL stay high through that cycle and be low on the next.
REQ-016 start while busy is high, including the done cycle, SHALL be ignored with no side effects.
REQ-017 Changes on value after acceptance SHALL NOT affect the frame in progress.
REQ-018 FSM states: IDLE, START_BIT, DATA_BITS, STOP_BIT; IDLE->START_BIT on an accepted start; START_BIT->DATA_BITS, then DATA_BITS->STOP_BIT after bit 7; STOP_BIT->START_BIT if characters remain, else IDLE with done.
REQ-019 Baud counter SHALL count 0..CLK_CYCLES-1 and wrap; bit index 0..7; character index 0..N+1.
REQ-020 Nibble-to-ASCII mapping: 0-9 -> 0x30+n; 10-15 -> 0x37+n.
REQ-021 uart_tx SHALL be driven directly from a register (glitch-free).

Reset
REQ-022 While rst is high: state IDLE, uart_tx=1, busy=0, done=0, all counters 0.
REQ-023 rst asserted mid-frame SHALL abort the frame on the next edge: uart_tx returns high, and done SHALL NOT pulse.
REQ-024 start asserted in the same cycle as rst SHALL be ignored.

Structure
REQ-025 A shared constants include SHALL hold ASCII_CR (8'h0D), ASCII_LF (8'h0A), and the 115,200-baud-at-10 MHz cycle count (87).
REQ-026 The design SHALL be split into one sub-module, uart_byte_tx: a byte serializer with a req/ready handshake that owns the baud counter and bit FSM. uart_hex_tx SHALL own the character sequencer and hex conversion.

Verification (CLK_CYCLES=4, N=4)
REQ-027 value=16'h1A2F, start pulse -> bytes 0x31,0x41,0x32,0x46,0x0D,0x0A on uart_tx; done at cycle 241; busy high for cycles 1-241.
REQ-028 value=16'h0000 then 16'hFFFF in back-to-back frames, second start issued the cycle after done -> "0000\r\n" then "FFFF\r\n", with no idle gap beyond one cycle.
REQ-029 start re-pulsed at cycles 50 and 241 of a frame, and value changed at cycle 10 -> exactly one frame sent, with the originally latched digits.
REQ-030 rst pulsed at cycle 100 mid-frame -> uart_tx=1 and busy=0 at cycle 101; done never pulses; a later start sends a complete, correct frame.
REQ-031 Bit timing: every bit level held exactly 4 cycles; start bit at cycles 1-4; stop bit of the first character at cycles 37-40.
REQ-032 Bench SHALL use a reference serial decoder to check every character, including the framing bits.

Source files
------------

// File: rtl/uart_hex_tx_pkg.sv
// Shared constants, state encoding and hex helper
// for the hex-frame UART transmitter.
package uart_hex_tx_pkg;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

  // 10 MHz / 115,200 baud, rounded
  localparam int BAUD_115200_AT_10MHZ = 87;

  typedef enum logic [1:0] {
    IDLE,
    START_BIT,
    DATA_BITS,
    STOP_BIT
  } tx_state_e;

  function automatic logic [7:0] hex_ascii(
    input logic [3:0] n
  );
    if (n < 4'd10) return 8'h30 + {4'h0, n};
    else           return 8'h37 + {4'h0, n};
  endfunction

endpackage

// File: rtl/uart_byte_tx.sv
// 8N1 byte serializer with req/ready handshake;
// owns the baud counter and the bit-level FSM.
module uart_byte_tx
  import uart_hex_tx_pkg::*;
#(
  parameter int CLK_CYCLES = BAUD_115200_AT_10MHZ
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req,
  input  logic [7:0] data,
  output logic       ready,
  output logic       tx
);

  localparam int CW =
    (CLK_CYCLES > 1) ? $clog2(CLK_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST =
    CW'(CLK_CYCLES - 1);

  tx_state_e      state, state_n;
  logic [CW-1:0]  cnt, cnt_n;
  logic [2:0]     bit_idx, bit_n;
  logic [7:0]     sh, sh_n;
  logic           tx_q, tx_n;
  logic           last;

  assign last = (cnt == CNT_LAST);
  assign tx   = tx_q;

  // State, counters and the registered line level
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      sh      <= '0;
      tx_q    <= 1'b1;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      bit_idx <= bit_n;
      sh      <= sh_n;
      tx_q    <= tx_n;
    end
  end

  // Next state; ready only when a new byte can
  // start on the very next cycle
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    bit_n   = bit_idx;
    sh_n    = sh;
    tx_n    = tx_q;
    ready   = 1'b0;
    unique case (state)
      IDLE: begin
        ready = 1'b1;
        cnt_n = '0;
        bit_n = '0;
        if (req) begin
          state_n = START_BIT;
          sh_n    = data;
          tx_n    = 1'b0;
        end
      end
      START_BIT: begin
        cnt_n = cnt + CW'(1);
        if (last) begin
          cnt_n   = '0;
          state_n = DATA_BITS;
          tx_n    = sh[0];
        end
      end
      DATA_BITS: begin
        cnt_n = cnt + CW'(1);
        if (last) begin
          cnt_n = '0;
          if (bit_idx == 3'd7) begin
            bit_n   = '0;
            state_n = STOP_BIT;
            tx_n    = 1'b1;
          end else begin
            bit_n = bit_idx + 3'd1;
            sh_n  = sh >> 1;
            tx_n  = sh[1];
          end
        end
      end
      STOP_BIT: begin
        cnt_n = cnt + CW'(1);
        if (last) begin
          cnt_n = '0;
          ready = 1'b1;
          if (req) begin
            state_n = START_BIT;
            sh_n    = data;
            tx_n    = 1'b0;
          end else begin
            state_n = IDLE;
            tx_n    = 1'b1;
          end
        end
      end
      default: begin
        state_n = IDLE;
        tx_n    = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/uart_hex_tx.sv
// Sends a value as N uppercase hex digits plus
// CR LF over UART; owns the character sequencer.
module uart_hex_tx
  import uart_hex_tx_pkg::*;
#(
  parameter int CLK_CYCLES = BAUD_115200_AT_10MHZ,
  parameter int N          = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [4*N-1:0] value,
  input  logic           start,
  output logic           busy,
  output logic           done,
  output logic           uart_tx
);

  localparam int NCH = N + 2;
  localparam int IW  = $clog2(NCH);
  localparam logic [IW-1:0] IDX_LAST = IW'(N + 1);

  logic [4*N-1:0] value_q;
  logic [IW-1:0]  char_idx;
  logic           active;
  logic           busy_q;
  logic           done_q;
  logic           start_acc;
  logic           last_char;
  logic           req;
  logic           ready;
  logic [7:0]     byte_data;

  function automatic logic [7:0] char_of(
    input logic [4*N-1:0] v,
    input logic [IW-1:0]  idx
  );
    logic [4*N-1:0] sh;
    sh = '0;
    if (int'(idx) < N) begin
      sh = v >> (4 * (N - 1 - int'(idx)));
      return hex_ascii(sh[3:0]);
    end else if (int'(idx) == N) begin
      return ASCII_CR;
    end else begin
      return ASCII_LF;
    end
  endfunction

  assign start_acc = start && !busy_q && !rst;
  assign last_char = (char_idx == IDX_LAST);
  assign busy      = busy_q;
  assign done      = done_q;

  // First character comes straight from value so
  // the start bit appears one cycle after start
  always_comb begin
    req       = start_acc || (active && !last_char);
    byte_data = start_acc
              ? char_of(value, '0)
              : char_of(value_q, char_idx + IW'(1));
  end

  // Character sequencer: latch, advance, finish
  always_ff @(posedge clk) begin
    if (rst) begin
      value_q  <= '0;
      char_idx <= '0;
      active   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start_acc) begin
        value_q  <= value;
        char_idx <= '0;
        active   <= 1'b1;
        busy_q   <= 1'b1;
      end else begin
        if (done_q) busy_q <= 1'b0;
        if (active && ready) begin
          if (last_char) begin
            active   <= 1'b0;
            done_q   <= 1'b1;
            char_idx <= '0;
          end else begin
            char_idx <= char_idx + IW'(1);
          end
        end
      end
    end
  end

  uart_byte_tx #(
    .CLK_CYCLES(CLK_CYCLES)
  ) u_byte (
    .clk  (clk),
    .rst  (rst),
    .req  (req),
    .data (byte_data),
    .ready(ready),
    .tx   (uart_tx)
  );

endmodule

// File: tb/tb_uart_hex_tx.sv
// Directed bench with scoreboard queue and a
// cycle-exact reference serial decoder.
module tb_uart_hex_tx;

  localparam int CC      = 4;
  localparam int N       = 4;
  localparam int NCH     = N + 2;
  localparam int DONE_AT = 1 + NCH * 10 * CC;

  logic        clk   = 1'b0;
  logic        rst   = 1'b1;
  logic        start = 1'b0;
  logic [15:0] value = '0;
  logic        busy;
  logic        done;
  logic        uart_tx;

  int errors   = 0;
  int checks   = 0;
  int chars_rx = 0;

  logic [7:0] exp_q[$];
  string      hexs = "0123456789ABCDEF";

  uart_hex_tx #(
    .CLK_CYCLES(CC),
    .N         (N)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .value  (value),
    .start  (start),
    .busy   (busy),
    .done   (done),
    .uart_tx(uart_tx)
  );

  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  // Reference decoder: every sample of all ten
  // bit periods must match the expected level
  int         pos = -1;
  logic [9:0] fbits;
  logic [9:0] obits;
  logic [7:0] eb;
  logic       tmg;

  always @(negedge clk) begin
    if (rst) begin
      pos = -1;
      exp_q.delete();
    end else begin
      if (pos < 0 && uart_tx === 1'b0) begin
        chk("rx_expected",
            32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) eb = exp_q.pop_front();
        else                   eb = 8'h00;
        fbits = {1'b1, eb, 1'b0};
        obits = '0;
        tmg   = 1'b1;
        pos   = 0;
      end
      if (pos >= 0) begin
        if (uart_tx !== fbits[pos / CC]) tmg = 1'b0;
        if (pos % CC == CC / 2)
          obits[pos / CC] = uart_tx;
        pos++;
        if (pos == 10 * CC) begin
          chk("rx_char", {21'b0, tmg, obits},
              {21'b0, 1'b1, fbits});
          chars_rx++;
          pos = -1;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_frame(input logic [15:0] v);
    logic [3:0] nib;
    logic [7:0] ch;
    for (int i = 0; i < N; i++) begin
      nib = v[15 - 4 * i -: 4];
      ch  = hexs[int'(nib)];
      exp_q.push_back(ch);
    end
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
  endtask

  // One frame; optional start re-pulses at cycles
  // pa/pb and a value change at cycle cv
  task automatic run_frame(
    input string       tag,
    input logic [15:0] v,
    input int          pa,
    input int          pb,
    input int          cv,
    input logic [15:0] nv
  );
    int   c;
    int   dc;
    logic bok;
    push_frame(v);
    value = v;
    start = 1'b1;
    tick();
    start = 1'b0;
    c = 1;
    chk({tag, "_tx_c1"}, 32'(uart_tx), 32'd0);
    chk({tag, "_busy_c1"}, 32'(busy), 32'd1);
    dc  = -1;
    bok = 1'b1;
    while (c < 2 * DONE_AT) begin
      start = (c == pa) || (c == pb);
      if (c == cv) value = nv;
      if (done === 1'b1) begin
        dc = c;
        break;
      end
      if (busy !== 1'b1) bok = 1'b0;
      tick();
      c++;
    end
    chk({tag, "_done_cycle"}, 32'(dc), 32'(DONE_AT));
    chk({tag, "_busy_held"}, 32'(bok), 32'd1);
    chk({tag, "_busy_at_done"}, 32'(busy), 32'd1);
    chk({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
    tick();
    start = 1'b0;
    chk({tag, "_busy_after"}, 32'(busy), 32'd0);
    chk({tag, "_done_after"}, 32'(done), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit hit");
    $fatal(1, "watchdog");
  end

  initial begin
    int   c;
    logic seen;
    rst   = 1'b1;
    start = 1'b1;
    value = 16'h1A2F;
    tick();
    tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_tx", 32'(uart_tx), 32'd1);
    chk("rst_done", 32'(done), 32'd0);
    rst   = 1'b0;
    start = 1'b0;
    tick();
    chk("rst_start_busy", 32'(busy), 32'd0);
    chk("rst_start_tx", 32'(uart_tx), 32'd1);
    tick();

    run_frame("f1a2f", 16'h1A2F, -1, -1, -1, '0);
    tick();
    tick();

    run_frame("f0000", 16'h0000, -1, -1, -1, '0);
    run_frame("fffff", 16'hFFFF, -1, -1, -1, '0);
    tick();

    run_frame("frepulse", 16'hBEEF, 50, DONE_AT,
              10, 16'h1234);
    seen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (busy !== 1'b0) seen = 1'b1;
      tick();
    end
    chk("repulse_no_second", 32'(seen), 32'd0);

    push_frame(16'h5A3C);
    value = 16'h5A3C;
    start = 1'b1;
    tick();
    start = 1'b0;
    c = 1;
    while (c < 100) begin
      tick();
      c++;
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_tx", 32'(uart_tx), 32'd1);
    chk("abort_busy", 32'(busy), 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (done === 1'b1) seen = 1'b1;
      tick();
    end
    chk("abort_no_done", 32'(seen), 32'd0);

    run_frame("fpost", 16'hC0DE, -1, -1, -1, '0);
    tick();
    tick();

    chk("chars_total", 32'(chars_rx), 32'(5 * NCH + 2));
    chk("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
